// File: rtl/uart_mem_bridge_pkg.sv
// rtl/uart_mem_bridge_pkg.sv - command/response codes and FSM state type for the UART memory bridge
package uart_mem_bridge_pkg;

  localparam logic [7:0] CMD_READ   = 8'h52;
  localparam logic [7:0] CMD_WRITE  = 8'h57;

  localparam logic [7:0] RSP_OK     = 8'h4B;
  localparam logic [7:0] RSP_ERR    = 8'h45;
  localparam logic [7:0] RSP_BADCMD = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD_ADDR,
    ST_CMD_DATA,
    ST_WAIT_GNT,
    ST_REQ,
    ST_WAIT_RSP,
    ST_TX_STATUS,
    ST_TX_DATA
  } state_e;

endpackage

// File: rtl/uart_mem_bridge.sv
// rtl/uart_mem_bridge.sv - UART byte-stream to 32-bit memory bus bridge for debug and boot loading
module uart_mem_bridge
  import uart_mem_bridge_pkg::*;
#(
  parameter int RX_TIMEOUT  = 10_000_000,
  parameter int RSP_TIMEOUT = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  input  logic        bus_gnt_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic        mem_err_i,
  input  logic [31:0] mem_rdata_i
);

  // One counter serves both the inter-byte and the bus-response timeout.
  localparam int TMO_MAX = (RX_TIMEOUT > RSP_TIMEOUT) ? RX_TIMEOUT : RSP_TIMEOUT;
  localparam int TW      = $clog2(TMO_MAX + 1);
  localparam logic [TW-1:0] RX_LAST  = TW'(RX_TIMEOUT - 1);
  localparam logic [TW-1:0] RSP_LAST = TW'(RSP_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    rsp_q, rsp_d;
  logic [31:0]   addr_q, addr_d;

  // Every output is a register so nothing glitches and all outputs clear in reset.
  logic          rx_ready_q, rx_ready_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          busy_q, busy_d;
  logic          mem_req_q, mem_req_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;

  logic rx_fire;
  logic tx_fire;

  assign rx_fire = rx_valid_i & rx_ready_q;
  assign tx_fire = tx_valid_q & tx_ready_i;

  // Next-state, datapath and registered-output decode for the command FSM.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    tmo_d       = tmo_q;
    rsp_d       = rsp_q;
    addr_d      = addr_q;
    mem_req_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          cnt_d   = 2'd0;
          tmo_d   = '0;
          shift_d = '0;
          if (rx_data_i == CMD_READ) begin
            we_d    = 1'b0;
            state_d = ST_CMD_ADDR;
          end else if (rx_data_i == CMD_WRITE) begin
            we_d    = 1'b1;
            state_d = ST_CMD_ADDR;
          end else begin
            rsp_d   = RSP_BADCMD;
            state_d = ST_TX_STATUS;
          end
        end
      end

      ST_CMD_ADDR, ST_CMD_DATA: begin
        if (rx_fire) begin
          // Fields arrive LSB first, so new bytes enter at the top.
          shift_d = {rx_data_i, shift_q[31:8]};
          tmo_d   = '0;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (state_q == ST_CMD_ADDR) begin
              addr_d  = {shift_d[31:2], 2'b00};
              state_d = we_q ? ST_CMD_DATA : ST_WAIT_GNT;
            end else begin
              state_d = ST_WAIT_GNT;
            end
          end
        end else if (tmo_q == RX_LAST) begin
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_WAIT_GNT: begin
        if (bus_gnt_i) begin
          state_d     = ST_REQ;
          mem_req_d   = 1'b1;
          mem_addr_d  = addr_q;
          mem_we_d    = we_q;
          mem_be_d    = 4'hF;
          mem_wdata_d = we_q ? shift_q : 32'h0;
          tmo_d       = '0;
        end
      end

      ST_REQ: begin
        state_d = ST_WAIT_RSP;
        tmo_d   = tmo_q + 1'b1;
      end

      ST_WAIT_RSP: begin
        tmo_d = tmo_q + 1'b1;
        if (mem_rvalid_i || (tmo_q == RSP_LAST)) begin
          state_d     = ST_TX_STATUS;
          mem_addr_d  = '0;
          mem_we_d    = 1'b0;
          mem_be_d    = 4'h0;
          mem_wdata_d = '0;
          if (mem_rvalid_i && !mem_err_i) begin
            rsp_d = RSP_OK;
            if (!we_q) begin
              shift_d = mem_rdata_i;
            end
          end else begin
            rsp_d = RSP_ERR;
          end
        end
      end

      ST_TX_STATUS: begin
        if (tx_fire) begin
          cnt_d   = 2'd0;
          state_d = ((rsp_q == RSP_OK) && !we_q) ? ST_TX_DATA : ST_IDLE;
        end
      end

      ST_TX_DATA: begin
        if (tx_fire) begin
          shift_d = {8'h00, shift_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_CMD_ADDR) || (state_d == ST_CMD_DATA);
    busy_d     = (state_d != ST_IDLE);
    tx_valid_d = (state_d == ST_TX_STATUS) || (state_d == ST_TX_DATA);
    if (state_d == ST_TX_STATUS) begin
      tx_data_d = rsp_d;
    end else if (state_d == ST_TX_DATA) begin
      tx_data_d = shift_d[7:0];
    end else begin
      tx_data_d = 8'h00;
    end
  end

  // State, datapath and output registers; reset aborts any command silently.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      cnt_q       <= 2'd0;
      shift_q     <= '0;
      tmo_q       <= '0;
      rsp_q       <= 8'h00;
      addr_q      <= '0;
      rx_ready_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tmo_q       <= tmo_d;
      rsp_q       <= rsp_d;
      addr_q      <= addr_d;
      rx_ready_q  <= rx_ready_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign rx_ready_o  = rx_ready_q;
  assign tx_valid_o  = tx_valid_q;
  assign tx_data_o   = tx_data_q;
  assign busy_o      = busy_q;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// tb/tb_uart_mem_bridge.sv - self-checking bench for uart_mem_bridge
module tb_uart_mem_bridge;

  localparam int RXT  = 40;
  localparam int RSPT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_ready = 1'b1;
  logic        gnt = 1'b1;
  logic        rvalid = 1'b0;
  logic        err = 1'b0;
  logic [31:0] rdata = 32'h0;

  logic        rx_ready_o, tx_valid_o, busy_o, mem_req_o, mem_we_o;
  logic [7:0]  tx_data_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;

  uart_mem_bridge #(.RX_TIMEOUT(RXT), .RSP_TIMEOUT(RSPT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_ready_o(rx_ready_o),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready),
    .busy_o(busy_o), .bus_gnt_i(gnt),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(rvalid), .mem_err_i(err), .mem_rdata_i(rdata)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // Reference model: memory contents as implied by the host command stream.
  logic [31:0] ref_mem [bit [31:0]];
  // Responder storage, written only from what the bridge puts on the bus.
  logic [31:0] bus_mem [bit [31:0]];

  int          lat = 1;
  bit          err_mode = 1'b0;
  int          pend = 0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_we = 1'b0;
  logic [3:0]  req_be = 4'h0;

  // Bus responder: answers each request after lat cycles (lat=0 means never).
  always begin
    @(posedge clk);
    #1;
    rvalid = 1'b0;
    err    = 1'b0;
    rdata  = 32'h0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        rvalid = 1'b1;
        err    = err_mode;
        rdata  = bus_mem.exists(pend_addr) ? bus_mem[pend_addr] : 32'h0;
      end
    end
    if (mem_req_o) begin
      req_addr  = mem_addr_o;
      req_we    = mem_we_o;
      req_be    = mem_be_o;
      req_wdata = mem_wdata_o;
      pend_addr = mem_addr_o;
      if (mem_we_o && !err_mode && lat > 0) bus_mem[mem_addr_o] = mem_wdata_o;
      if (lat > 0) pend = lat;
    end
  end

  logic [7:0] tx_q[$];
  int  cyc = 0, req_cyc = 0, txrise_cyc = 0, req_count = 0, run = 0, max_run = 0, stab_err = 0;
  logic prev_txv = 1'b0, prev_txr = 1'b0;
  logic [7:0] prev_txd = 8'h00;

  // Monitor: collects transmitted bytes and timing of requests and responses.
  always @(negedge clk) begin
    cyc++;
    if (tx_valid_o && tx_ready) tx_q.push_back(tx_data_o);
    if (tx_valid_o && !prev_txv) txrise_cyc = cyc;
    if (prev_txv && !prev_txr && tx_valid_o && (tx_data_o != prev_txd)) stab_err++;
    prev_txv = tx_valid_o;
    prev_txr = tx_ready;
    prev_txd = tx_data_o;
    if (mem_req_o) begin
      req_count++;
      req_cyc = cyc;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  logic [7:0] cmd_q[$];
  logic [7:0] exp_q[$];

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    bit took;
    k = 0;
    took = 1'b0;
    rx_valid = 1'b1;
    rx_data = b;
    while (!took && k < 100) begin
      @(negedge clk);
      took = rx_ready_o;
      @(posedge clk);
      #1;
      k++;
    end
    rx_valid = 1'b0;
    if (!took) chk("rx_accept", 64'd0, 64'd1);
  endtask

  task automatic send_cmd();
    foreach (cmd_q[i]) send_byte(cmd_q[i]);
    cmd_q.delete();
  endtask

  task automatic expect_rsp(input string tag);
    int k;
    k = 0;
    while (tx_q.size() < exp_q.size() && k < 400) begin
      tick();
      k++;
    end
    chk({tag, "_busy_fall"}, busy_o, 1'b0);
    tick(4);
    chk({tag, "_nbytes"}, tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < tx_q.size()) chk({tag, "_byte"}, tx_q[i], exp_q[i]);
    end
    tx_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic build_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    cmd_q.push_back(op);
    for (int i = 0; i < 4; i++) cmd_q.push_back(a[8*i +: 8]);
    if (op == 8'h57) for (int i = 0; i < 4; i++) cmd_q.push_back(d[8*i +: 8]);
  endtask

  task automatic exp_read(input logic [31:0] a);
    logic [31:0] v;
    v = ref_rd(a & ~32'h3);
    exp_q.push_back(8'h4B);
    for (int i = 0; i < 4; i++) exp_q.push_back(v[8*i +: 8]);
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d);
    build_cmd(8'h57, a, d);
    ref_mem[a & ~32'h3] = d;
    exp_q.push_back(8'h4B);
    send_cmd();
    expect_rsp(tag);
    chk({tag, "_addr"}, req_addr, a & ~32'h3);
    chk({tag, "_we"}, req_we, 1'b1);
    chk({tag, "_be"}, req_be, 4'hF);
    chk({tag, "_wdata"}, req_wdata, d);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a);
    build_cmd(8'h52, a, 32'h0);
    exp_read(a);
    send_cmd();
    expect_rsp(tag);
    chk({tag, "_addr"}, req_addr, a & ~32'h3);
    chk({tag, "_we"}, req_we, 1'b0);
  endtask

  initial begin
    logic [31:0] a, d, r;
    int rc, k;

    // Reset state
    tick(2);
    chk("reset_ctrl", {rx_ready_o, tx_valid_o, tx_data_o, busy_o, mem_req_o, mem_we_o, mem_be_o}, 64'd0);
    chk("reset_bus", {mem_addr_o, mem_wdata_o}, 64'd0);
    rst_n = 1'b1;
    tick(2);
    chk("idle_ready", {rx_ready_o, busy_o}, 2'b10);
    chk("idle_addr", mem_addr_o, 32'h0);

    // Basic write and read
    do_write("wr1", 32'h0000_0010, 32'hDEAD_BEEF);
    bus_mem[32'h10] = 32'hCAFE_F00D;
    ref_mem[32'h10] = 32'hCAFE_F00D;
    do_read("rd1", 32'h0000_0013);

    // Bus error response
    err_mode = 1'b1;
    build_cmd(8'h52, 32'hFF00_0008, 32'h0);
    exp_q.push_back(8'h45);
    send_cmd();
    expect_rsp("buserr");
    err_mode = 1'b0;

    // No response: timeout, late rvalid ignored
    lat = RSPT + 4;
    build_cmd(8'h52, 32'h0000_0020, 32'h0);
    exp_q.push_back(8'h45);
    send_cmd();
    expect_rsp("rsptmo");
    chk("rsptmo_latency", txrise_cyc - req_cyc, RSPT);
    tick(12);
    chk("late_rvalid_ignored", tx_q.size(), 0);
    chk("late_rvalid_idle", busy_o, 1'b0);
    lat = 1;

    // Unknown command
    cmd_q.push_back(8'h41);
    exp_q.push_back(8'h3F);
    send_cmd();
    expect_rsp("badcmd");

    // Inter-byte timeout
    cmd_q.push_back(8'h52);
    cmd_q.push_back(8'h10);
    send_cmd();
    rc = req_count;
    tick(RXT - 3);
    chk("rxtmo_still_busy", busy_o, 1'b1);
    tick(6);
    chk("rxtmo_idle", {busy_o, rx_ready_o}, 2'b01);
    chk("rxtmo_no_req", req_count, rc);
    chk("rxtmo_no_tx", tx_q.size(), 0);
    do_read("rd_after_tmo", 32'h0000_0010);

    // Randomized write/read traffic against the reference model
    for (int n = 0; n < 8; n++) begin
      r = $urandom();
      a = r & 32'hF000_00FC;
      d = $urandom();
      do_write("rnd_wr", a, d);
      r = $urandom();
      do_read("rnd_rd", a | (r & 32'h3));
      r = $urandom();
      do_read("rnd_rd2", (r & 32'hF000_00FF));
    end

    // Grant stall
    gnt = 1'b0;
    build_cmd(8'h52, 32'h0000_0010, 32'h0);
    exp_read(32'h0000_0010);
    send_cmd();
    rc = req_count;
    tick(20);
    chk("gnt_hold_no_req", req_count, rc);
    gnt = 1'b1;
    chk("gnt_rise_no_req", mem_req_o, 1'b0);
    tick();
    chk("req_after_gnt", mem_req_o, 1'b1);
    expect_rsp("gnt_rd");

    // Transmitter stall
    tx_ready = 1'b0;
    build_cmd(8'h52, 32'h0000_0010, 32'h0);
    exp_read(32'h0000_0010);
    send_cmd();
    k = 0;
    while (!tx_valid_o && k < 60) begin
      tick();
      k++;
    end
    tick(10);
    chk("stall_valid", tx_valid_o, 1'b1);
    chk("stall_data", tx_data_o, 8'h4B);
    chk("stall_no_hs", tx_q.size(), 0);
    tx_ready = 1'b1;
    expect_rsp("stall_rd");
    chk("stall_stable", stab_err, 0);

    // Reset during WAIT_RSP
    lat = 0;
    rc = req_count;
    build_cmd(8'h52, 32'h0000_0020, 32'h0);
    send_cmd();
    k = 0;
    while (req_count == rc && k < 40) begin
      tick();
      k++;
    end
    tick(2);
    rst_n = 1'b0;
    #1;
    chk("rst_async_ctrl", {rx_ready_o, tx_valid_o, tx_data_o, busy_o, mem_req_o, mem_we_o, mem_be_o}, 64'd0);
    chk("rst_async_bus", {mem_addr_o, mem_wdata_o}, 64'd0);
    tick(2);
    rst_n = 1'b1;
    lat = 1;
    tick(2);
    chk("rst_no_rsp", tx_q.size(), 0);
    do_read("rd_after_rst", 32'h0000_0010);

    chk("req_single_cycle", max_run, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/uart_mem_bridge.md
Name: uart_mem_bridge

Overview:
- Debug and boot-load bridge: a host on the UART issues word reads and writes on the 32-bit core memory bus.
- Consumes received bytes from a byte-stream receiver (valid/ready) and produces response bytes to a byte-stream transmitter (valid/ready).
- Acts as a bus initiator with the same req/rvalid/err/rdata protocol the core uses. SRAM and hwreg responders are reached through an external arbiter mux.
- Lets memory images be loaded and inspected without the core running.

Parameters:
RX_TIMEOUT, 10_000_000, max idle cycles between bytes of one command before silent abort (>=2)
RSP_TIMEOUT, 256, max cycles from mem_req_o to mem_rvalid_i before error status (>=2)

Ports:
clk_i  in  1  clock, single domain
rst_ni  in  1  reset, asynchronous, active-low
rx_valid_i  in  1  received byte valid
rx_data_i  in  8  received byte
rx_ready_o  out  1  bridge accepts byte this cycle
tx_valid_o  out  1  response byte valid
tx_data_o  out  8  response byte
tx_ready_i  in  1  transmitter accepts byte
busy_o  out  1  command in progress; arbiter request for the bus
bus_gnt_i  in  1  arbiter grants bus to bridge
mem_req_o  out  1  bus request, single-cycle pulse
mem_addr_o  out  32  word address, bits [1:0] always 0
mem_we_o  out  1  write enable
mem_be_o  out  4  byte enables, always 4'hF
mem_wdata_o  out  32  write data
mem_rvalid_i  in  1  response valid
mem_err_i  in  1  response error, qualified by mem_rvalid_i
mem_rdata_i  in  32  read data, qualified by mem_rvalid_i

Behaviour:
- Reset: all outputs 0; state IDLE; counters and shift registers cleared. Reset asserted mid-operation aborts immediately, with no response byte.
- Protocol: all multi-byte fields are LSB first.
  - 0x52 'R' + 4 address bytes → read.
  - 0x57 'W' + 4 address + 4 data bytes → write.
  - Any other command byte → respond 0x3F '?' and return to IDLE.
- Responses: read OK = 0x4B then 4 rdata bytes; write OK = 0x4B; any error = 0x45 only.
- States:
  - IDLE: rx_ready_o=1, busy_o=0.
  - CMD_ADDR: collect 4 address bytes.
  - CMD_DATA: collect 4 data bytes, write only.
  - WAIT_GNT
  - REQ
  - WAIT_RSP
  - TX_STATUS
  - TX_DATA: byte counter 0..3.
- busy_o: high from acceptance of a valid command byte until the last response byte handshakes.
- rx_ready_o: 1 only in IDLE, CMD_ADDR and CMD_DATA. A byte is taken when rx_valid_i & rx_ready_o.
- Inter-byte timeout: counter resets on each accepted byte in CMD_ADDR/CMD_DATA. Reaching RX_TIMEOUT returns to IDLE: no bus access, no response.
- WAIT_GNT: when bus_gnt_i=1, next cycle is REQ with mem_req_o=1 for exactly one cycle.
  - mem_addr_o/mem_we_o/mem_be_o/mem_wdata_o are registered, stable from REQ through WAIT_RSP.
  - They are 0 in IDLE.
- WAIT_RSP: cycle counter starts at REQ.
  - mem_rvalid_i & !mem_err_i → latch rdata; go to TX_STATUS with 0x4B.
  - mem_rvalid_i & mem_err_i → 0x45.
  - Counter reaching RSP_TIMEOUT with no rvalid → 0x45.
  - mem_rvalid_i seen in any other state is ignored.
- TX: tx_valid_o held until tx_ready_i; tx_data_o stable while tx_valid_o & !tx_ready_i. One byte per handshake; no bubble required.
  - Read OK: TX_STATUS → TX_DATA.
  - Otherwise: TX_STATUS → IDLE.
  - After the 4th data byte → IDLE.
- Unknown command byte: goes directly to TX_STATUS with 0x3F.
- Address bits [1:0] received from the host are discarded.

Decomposition:
- Package uart_mem_bridge_pkg:
  - CMD_READ=8'h52, CMD_WRITE=8'h57.
  - RSP_OK=8'h4B, RSP_ERR=8'h45, RSP_BADCMD=8'h3F.
  - State enum type.
- No sub-module. Byte assembly uses a 32-bit shift register; one shared timeout counter is sized by the max of both timeouts.
- Top-level integration: the bridge byte ports connect to uart_rx/uart_tx; an arbiter muxes the bridge and the core onto the bus.

Test Plan:
1. Write, gnt=1, tx_ready=1: bytes 57 10 00 00 00 EF BE AD DE → one-cycle mem_req_o with addr 0x00000010, we=1, be=F, wdata 0xDEADBEEF; rvalid next cycle → tx 4B; busy_o falls after that handshake.
2. Read: 52 13 00 00 00; responder returns rdata 0xCAFEF00D one cycle after req → addr 0x00000010 (bits [1:0] cleared), we=0; tx 4B 0D F0 FE CA.
3. Bus error: read of 0xFF00_0008 with rvalid=1, err=1 → tx 45 only, no data bytes, back to IDLE.
4. No response: rvalid never asserted → tx 45 exactly RSP_TIMEOUT cycles after req; an rvalid arriving later is ignored with no extra tx.
5. Command errors:
   - 0x41 → tx 3F.
   - 52 10 then silence for RX_TIMEOUT cycles → no req, no tx, back in IDLE.
   - A following full read completes normally.
6. Stalls and reset:
   - bus_gnt_i low for 20 cycles → no mem_req_o until the cycle after gnt rises.
   - tx_ready_i low for 10 cycles → tx_data_o stable.
   - rst_ni pulse during WAIT_RSP → all outputs 0 asynchronously; next command works.
